// File: rtl/pipe_ctrl.sv
// Pipeline control: stall vector, exception/ERTN flush with redirect, and
// a pending-branch register that holds a redirect while the PC is stalled.
module pipe_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        pause_req_if,
   input  logic        pause_req_id,
   input  logic        pause_req_ex,
   input  logic        pause_req_mem,
   input  logic        is_branch_i,
   input  logic [31:0] branch_target_addr_i,
   input  logic        exception_i,
   input  logic        ertn_i,
   input  logic [31:0] eentry_i,
   input  logic [31:0] era_i,
   output logic [5:0]  pause_o,
   output logic        exception_flush_o,
   output logic [31:0] exception_handle_pc_o,
   output logic        is_branch_o,
   output logic [31:0] branch_target_addr_o
);

   localparam int unsigned AW = 32;
   localparam int unsigned PW = 6;

   typedef enum logic {
      RUN        = 1'b0,
      FLUSH_WAIT = 1'b1
   } state_t;

   state_t        state;
   logic          pend_valid;
   logic [AW-1:0] pend_addr;

   logic          in_run;
   logic          flush;
   logic          branch_in;
   logic [PW-1:0] req_vec;

   // Stall vector from the highest requesting stage
   always_comb begin
      req_vec = '0;
      if (pause_req_mem)     req_vec = 6'b011111;
      else if (pause_req_ex) req_vec = 6'b001111;
      else if (pause_req_id) req_vec = 6'b000111;
      else if (pause_req_if) req_vec = 6'b000011;
   end

   // Flush, redirect and stall outputs; a flush or the wait cycle drops stalls
   always_comb begin
      in_run                = (state == RUN);
      flush                 = in_run && (exception_i || ertn_i);
      branch_in             = in_run && is_branch_i;
      pause_o               = '0;
      exception_flush_o     = flush;
      exception_handle_pc_o = '0;
      is_branch_o           = 1'b0;
      branch_target_addr_o  = pend_valid ? pend_addr : branch_target_addr_i;
      if (flush) begin
         exception_handle_pc_o = exception_i ? eentry_i : era_i;
      end else if (in_run) begin
         pause_o     = req_vec;
         is_branch_o = branch_in || pend_valid;
      end
   end

   // FSM state and pending-branch register
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RUN;
         pend_valid <= 1'b0;
         pend_addr  <= '0;
      end else begin
         case (state)
            RUN:        state <= flush ? FLUSH_WAIT : RUN;
            FLUSH_WAIT: state <= RUN;
            default:    state <= RUN;
         endcase
         if (flush) begin
            pend_valid <= 1'b0;
         end else if (pend_valid) begin
            // PC consumes the held redirect on its first unstalled cycle
            if (!pause_o[0]) pend_valid <= 1'b0;
         end else if (branch_in && pause_o[0]) begin
            pend_valid <= 1'b1;
            pend_addr  <= branch_target_addr_i;
         end
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: cycle-by-cycle vector table plus
// hand-written multi-cycle sequences.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        pause_req_if, pause_req_id, pause_req_ex, pause_req_mem;
   logic        is_branch_i;
   logic [31:0] branch_target_addr_i;
   logic        exception_i, ertn_i;
   logic [31:0] eentry_i, era_i;
   logic [5:0]  pause_o;
   logic        exception_flush_o;
   logic [31:0] exception_handle_pc_o;
   logic        is_branch_o;
   logic [31:0] branch_target_addr_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .clk                   (clk),
      .rst                   (rst),
      .pause_req_if          (pause_req_if),
      .pause_req_id          (pause_req_id),
      .pause_req_ex          (pause_req_ex),
      .pause_req_mem         (pause_req_mem),
      .is_branch_i           (is_branch_i),
      .branch_target_addr_i  (branch_target_addr_i),
      .exception_i           (exception_i),
      .ertn_i                (ertn_i),
      .eentry_i              (eentry_i),
      .era_i                 (era_i),
      .pause_o               (pause_o),
      .exception_flush_o     (exception_flush_o),
      .exception_handle_pc_o (exception_handle_pc_o),
      .is_branch_o           (is_branch_o),
      .branch_target_addr_o  (branch_target_addr_o)
   );

   // req = {mem, ex, id, if}
   typedef struct {
      string       name;
      logic        rst;
      logic [3:0]  req;
      logic        exc;
      logic        ertn;
      logic        br;
      logic [31:0] tgt;
      logic [31:0] eentry;
      logic [31:0] era;
      logic [5:0]  e_pause;
      logic        e_flush;
      logic [31:0] e_hpc;
      logic        e_bro;
      logic [31:0] e_btgt;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [3:0] req, input logic exc,
                        input logic ertn, input logic br, input logic [31:0] tgt,
                        input logic [31:0] ee, input logic [31:0] ea);
      rst = r;
      {pause_req_mem, pause_req_ex, pause_req_id, pause_req_if} = req;
      exception_i = exc; ertn_i = ertn; is_branch_i = br;
      branch_target_addr_i = tgt; eentry_i = ee; era_i = ea;
   endtask

   task automatic check_all(input string nm, input logic [5:0] p, input logic f,
                            input logic [31:0] h, input logic b, input logic [31:0] t);
      chk({nm, ".pause"}, 32'(pause_o), 32'(p));
      chk({nm, ".flush"}, 32'(exception_flush_o), 32'(f));
      chk({nm, ".hpc"}, exception_handle_pc_o, h);
      chk({nm, ".bro"}, 32'(is_branch_o), 32'(b));
      chk({nm, ".btgt"}, branch_target_addr_o, t);
   endtask

   // Drive at negedge, sample 1 ns later (well before the next posedge)
   task automatic step(input logic r, input logic [3:0] req, input logic exc,
                       input logic ertn, input logic br, input logic [31:0] tgt,
                       input logic [31:0] ee, input logic [31:0] ea);
      @(negedge clk);
      drive(r, req, exc, ertn, br, tgt, ee, ea);
      #1;
   endtask

   localparam logic [31:0] EE = 32'h1C00_0000;
   localparam logic [31:0] EA = 32'h0000_0120;

   initial begin
      drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

      // Each row is one cycle; rows run back to back from a fresh reset
      vecs.push_back('{"idle",      0, 4'b0000, 0, 0, 0, 32'h0,   EE, EA, 6'b000000, 0, 32'h0, 0, 32'h0});
      vecs.push_back('{"ex_if",     0, 4'b0101, 0, 0, 0, 32'h0,   EE, EA, 6'b001111, 0, 32'h0, 0, 32'h0});
      vecs.push_back('{"mem",       0, 4'b1000, 0, 0, 0, 32'h0,   EE, EA, 6'b011111, 0, 32'h0, 0, 32'h0});
      vecs.push_back('{"id",        0, 4'b0010, 0, 0, 0, 32'h0,   EE, EA, 6'b000111, 0, 32'h0, 0, 32'h0});
      vecs.push_back('{"if",        0, 4'b0001, 0, 0, 0, 32'h0,   EE, EA, 6'b000011, 0, 32'h0, 0, 32'h0});
      vecs.push_back('{"all_req",   0, 4'b1111, 0, 0, 0, 32'h0,   EE, EA, 6'b011111, 0, 32'h0, 0, 32'h0});
      vecs.push_back('{"br_free",   0, 4'b0000, 0, 0, 1, 32'h300, EE, EA, 6'b000000, 0, 32'h0, 1, 32'h300});
      vecs.push_back('{"after_br",  0, 4'b0000, 0, 0, 0, 32'h44,  EE, EA, 6'b000000, 0, 32'h0, 0, 32'h44});
      vecs.push_back('{"exc_stall", 0, 4'b1000, 1, 0, 1, 32'h500, EE, EA, 6'b000000, 1, EE,    0, 32'h500});
      vecs.push_back('{"fw_held",   0, 4'b1000, 1, 0, 1, 32'h600, EE, EA, 6'b000000, 0, 32'h0, 0, 32'h600});
      vecs.push_back('{"rearm",     0, 4'b0000, 1, 0, 0, 32'h0,   EE, EA, 6'b000000, 1, EE,    0, 32'h0});
      vecs.push_back('{"fw_idle1",  0, 4'b0000, 0, 0, 0, 32'h0,   EE, EA, 6'b000000, 0, 32'h0, 0, 32'h0});
      vecs.push_back('{"ertn",      0, 4'b0000, 0, 1, 0, 32'h0,   EE, EA, 6'b000000, 1, EA,    0, 32'h0});
      vecs.push_back('{"fw_idle2",  0, 4'b0000, 0, 0, 0, 32'h0,   EE, EA, 6'b000000, 0, 32'h0, 0, 32'h0});
      vecs.push_back('{"exc_ertn",  0, 4'b0000, 1, 1, 0, 32'h0,   EE, EA, 6'b000000, 1, EE,    0, 32'h0});
      vecs.push_back('{"fw_idle3",  0, 4'b0000, 0, 0, 0, 32'h0,   EE, EA, 6'b000000, 0, 32'h0, 0, 32'h0});
      vecs.push_back('{"in_reset",  1, 4'b0000, 0, 0, 0, 32'h0,   EE, EA, 6'b000000, 0, 32'h0, 0, 32'h0});

      // Reset state
      step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      check_all("reset", 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      check_all("post_reset", 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].req, vecs[i].exc, vecs[i].ertn, vecs[i].br,
              vecs[i].tgt, vecs[i].eentry, vecs[i].era);
         check_all(vecs[i].name, vecs[i].e_pause, vecs[i].e_flush, vecs[i].e_hpc,
                   vecs[i].e_bro, vecs[i].e_btgt);
      end

      // Stalled branch held for three cycles, consumed on first free cycle
      step(1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 32'h200, EE, EA);
      check_all("hold0", 6'b000111, 1'b0, 32'h0, 1'b1, 32'h200);
      step(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 32'hDEAD, EE, EA);
      check_all("hold1", 6'b000111, 1'b0, 32'h0, 1'b1, 32'h200);
      step(1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 32'hBEEF, EE, EA);
      check_all("hold2_ignore_new", 6'b000111, 1'b0, 32'h0, 1'b1, 32'h200);
      step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'hDEAD, EE, EA);
      check_all("consume", 6'b000000, 1'b0, 32'h0, 1'b1, 32'h200);
      step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'hDEAD, EE, EA);
      check_all("after_consume", 6'b000000, 1'b0, 32'h0, 1'b0, 32'hDEAD);

      // Pending branch killed by an exception
      step(1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 32'h700, EE, EA);
      check_all("pend_set", 6'b000111, 1'b0, 32'h0, 1'b1, 32'h700);
      step(1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 32'h0, EE, EA);
      chk("kill.flush", 32'(exception_flush_o), 32'd1);
      chk("kill.bro", 32'(is_branch_o), 32'd0);
      chk("kill.pause", 32'(pause_o), 32'd0);
      chk("kill.hpc", exception_handle_pc_o, EE);
      step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0, EE, EA);
      chk("kill_fw.bro", 32'(is_branch_o), 32'd0);
      step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h44, EE, EA);
      check_all("kill_after", 6'b0, 1'b0, 32'h0, 1'b0, 32'h44);

      // Reset with a pending branch: next cycle all zero, back in RUN
      step(1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 32'h900, EE, EA);
      check_all("pend_set2", 6'b000011, 1'b0, 32'h0, 1'b1, 32'h900);
      step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0, EE, EA);
      step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      check_all("rst_pend", 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);

      // Reset while in FLUSH_WAIT: next cycle is RUN so an exception flushes
      step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h0, EE, EA);
      chk("pre_rst_fw.flush", 32'(exception_flush_o), 32'd1);
      step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0, EE, EA);
      step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      check_all("rst_fw_idle", 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h0, EE, EA);
      chk("rst_fw_run.flush", 32'(exception_flush_o), 32'd1);
      chk("rst_fw_run.hpc", exception_handle_pc_o, EE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
